// File: rtl/fpaddsub_pkg.sv
// Shared types and constants for the FP add/sub arbiter slice.
// Exception vector layout is {any, ANaN, BNaN, AInf, BInf}.
package fpaddsub_pkg;

    localparam int FP_W  = 32;
    localparam int EXC_W = 5;

    localparam int EXC_ANY  = 4;
    localparam int EXC_ANAN = 3;
    localparam int EXC_BNAN = 2;
    localparam int EXC_AINF = 1;
    localparam int EXC_BINF = 0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // bit 0 grants req0, bit 1 grants req1; last is the id granted last
    function automatic logic [1:0] rr_grant(
        input logic [1:0] v,
        input logic       last
    );
        logic [1:0] g;
        g = v;
        if (v == 2'b11)
            g = last ? 2'b01 : 2'b10;
        return g;
    endfunction

endpackage

// File: rtl/fpaddsub_tag_pipe.sv
// Shift register of {valid, id} tags tracking in-flight datapath operations.
// Clears asynchronously; empty is high when no stage holds a valid tag.
module fpaddsub_tag_pipe
    import fpaddsub_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  tag_t din,
    output tag_t dout,
    output logic empty
);

    tag_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++)
                stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        empty = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            if (stage[i].valid)
                empty = 1'b0;
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fpaddsub_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FP add/sub pipeline.
// Define FPADDSUB_ARB_STATS_EN to add saturating per-requester issue counters.
module fpaddsub_arbiter
    import fpaddsub_pkg::*;
#(
    parameter int LATENCY = 4
`ifdef FPADDSUB_ARB_STATS_EN
   ,parameter int CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [FP_W-1:0]  req0_a,
    input  logic [FP_W-1:0]  req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [FP_W-1:0]  req1_a,
    input  logic [FP_W-1:0]  req1_b,
    input  logic             req1_op,
    output logic             fp_valid,
    output logic [FP_W-1:0]  fp_a,
    output logic [FP_W-1:0]  fp_b,
    output logic             fp_op,
    input  logic [FP_W-1:0]  fp_result,
    input  logic [EXC_W-1:0] fp_exc,
    output logic             res0_valid,
    output logic             res1_valid,
    output logic [FP_W-1:0]  res_data,
    output logic [EXC_W-1:0] res_exc,
    output logic             busy
`ifdef FPADDSUB_ARB_STATS_EN
   ,output logic [CNT_W-1:0] issue_cnt0,
    output logic [CNT_W-1:0] issue_cnt1
`endif
);

    state_t     state;
    state_t     state_nx;
    logic       last;
    logic [1:0] gnt;
    logic       xfer;
    logic       xid;
    tag_t       tin;
    tag_t       tout;
    logic       empty;

    assign gnt = (state == RUN && enable)
               ? rr_grant({req1_valid, req0_valid}, last)
               : 2'b00;

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign xfer       = |gnt;
    assign xid        = gnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (enable) state_nx = RUN;
            RUN:     if (!enable) state_nx = empty ? IDLE : DRAIN;
            DRAIN:   if (empty) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // pointer resets to "req1 granted last" so req0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (xfer)
            last <= xid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fp_valid <= 1'b0;
            fp_a     <= '0;
            fp_b     <= '0;
            fp_op    <= 1'b0;
        end else begin
            fp_valid <= xfer;
            if (xfer) begin
                fp_a  <= xid ? req1_a  : req0_a;
                fp_b  <= xid ? req1_b  : req0_b;
                fp_op <= xid ? req1_op : req0_op;
            end
        end
    end

    assign tin.valid = xfer;
    assign tin.id    = xid;

    // one extra stage covers the operand register ahead of the datapath
    fpaddsub_tag_pipe #(
        .DEPTH (LATENCY + 1)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .din   (tin),
        .dout  (tout),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res0_valid <= 1'b0;
            res1_valid <= 1'b0;
            res_data   <= '0;
            res_exc    <= '0;
        end else begin
            res0_valid <= tout.valid & ~tout.id;
            res1_valid <= tout.valid &  tout.id;
            if (tout.valid) begin
                res_data <= fp_result;
                res_exc  <= fp_exc;
            end
        end
    end

    // result registers keep busy high through the final result pulse
    assign busy = (state != IDLE) | ~empty | res0_valid | res1_valid;

`ifdef FPADDSUB_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt0 <= '0;
            issue_cnt1 <= '0;
        end else begin
            if (gnt[0] && issue_cnt0 != CNT_MAX)
                issue_cnt0 <= issue_cnt0 + 1'b1;
            if (gnt[1] && issue_cnt1 != CNT_MAX)
                issue_cnt1 <= issue_cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fpaddsub_arbiter.sv
// Self-checking bench for fpaddsub_arbiter with a behavioural FP datapath.
// Expected results are queued on each transfer and checked on result pulses.
module tb_fpaddsub_arbiter;
    import fpaddsub_pkg::*;

    localparam int LAT = 4;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_op, req1_op;
    logic        fp_valid;
    logic [31:0] fp_a, fp_b;
    logic        fp_op;
    logic [31:0] fp_result;
    logic [4:0]  fp_exc;
    logic        res0_valid, res1_valid;
    logic [31:0] res_data;
    logic [4:0]  res_exc;
    logic        busy;
`ifdef FPADDSUB_ARB_STATS_EN
    logic [1:0]  issue_cnt0, issue_cnt1;
`endif

    fpaddsub_arbiter #(
        .LATENCY (LAT)
`ifdef FPADDSUB_ARB_STATS_EN
       ,.CNT_W   (2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .fp_valid   (fp_valid),
        .fp_a       (fp_a),
        .fp_b       (fp_b),
        .fp_op      (fp_op),
        .fp_result  (fp_result),
        .fp_exc     (fp_exc),
        .res0_valid (res0_valid),
        .res1_valid (res1_valid),
        .res_data   (res_data),
        .res_exc    (res_exc),
        .busy       (busy)
`ifdef FPADDSUB_ARB_STATS_EN
       ,.issue_cnt0 (issue_cnt0),
        .issue_cnt1 (issue_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    int nres = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural datapath (normal numbers, NaN, Inf)
    function automatic real s2r(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0)
            return 0.0;
        e = {3'b000, s[30:23]} + 11'd896;
        return $bitstoreal({s[31], e, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0)
            return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [36:0] dp_model(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic op);
        logic [4:0] e;
        logic       an, bn, ai, bi;
        real        r;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        e = '0;
        e[EXC_ANAN] = an;
        e[EXC_BNAN] = bn;
        e[EXC_AINF] = ai;
        e[EXC_BINF] = bi;
        e[EXC_ANY]  = an | bn | ai | bi;
        if (an || bn)
            return {e, 32'h7FC00000};
        if (ai)
            return {e, a};
        if (bi)
            return {e, b};
        r = op ? s2r(a) - s2r(b) : s2r(a) + s2r(b);
        return {e, r2s(r)};
    endfunction

    logic [36:0] dp_pipe [LAT];

    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--)
            dp_pipe[i] <= dp_pipe[i-1];
        dp_pipe[0] <= fp_valid ? dp_model(fp_a, fp_b, fp_op) : 37'd0;
    end

    assign fp_result = dp_pipe[LAT-1][31:0];
    assign fp_exc    = dp_pipe[LAT-1][36:32];

    // ---------------- scoreboard monitor
    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [4:0]  exc;
        int          due;
    } sb_t;

    sb_t         sb[$];
    sb_t         ent;
    logic [31:0] exp_d [2];
    logic [4:0]  exp_e [2];
    logic        prev_x;
    logic [31:0] prev_a, prev_b;
    logic        prev_op;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_x = 1'b0;
        end else begin
            chk("fp_valid", fp_valid, prev_x);
            if (prev_x) begin
                chk("fp_a", fp_a, prev_a);
                chk("fp_b", fp_b, prev_b);
                chk("fp_op", fp_op, prev_op);
            end
            if (res0_valid && res1_valid)
                chk("res one-hot", {res1_valid, res0_valid}, 2'b01);
            if (req0_ready && req1_ready)
                chk("ready one-hot", {req1_ready, req0_ready}, 2'b01);
            if (res0_valid || res1_valid) begin
                nres++;
                if (sb.size() == 0) begin
                    chk("unexpected res", {res1_valid, res0_valid}, 2'b00);
                end else begin
                    ent = sb.pop_front();
                    chk("res id", res1_valid, ent.id);
                    chk("res_data", res_data, ent.data);
                    chk("res_exc", res_exc, ent.exc);
                    chk("res cycle", cyc, ent.due);
                end
            end
            prev_x = 1'b0;
            if (req0_valid && req0_ready) begin
                sb.push_back('{1'b0, exp_d[0], exp_e[0], cyc + LAT + 2});
                prev_x  = 1'b1;
                prev_a  = req0_a;
                prev_b  = req0_b;
                prev_op = req0_op;
            end
            if (req1_valid && req1_ready) begin
                sb.push_back('{1'b1, exp_d[1], exp_e[1], cyc + LAT + 2});
                prev_x  = 1'b1;
                prev_a  = req1_a;
                prev_b  = req1_b;
                prev_op = req1_op;
            end
        end
    end

    // ---------------- stimulus helpers (enter and leave at posedge+1)
    task automatic drive(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic op,
                         input logic [31:0] ed, input logic [4:0] ee);
        exp_d[id] = ed;
        exp_e[id] = ee;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
    endtask

    task automatic issue(input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic op,
                         input logic [31:0] ed, input logic [4:0] ee);
        logic got;
        got = 1'b0;
        drive(id, a, b, op, ed, ee);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            @(posedge clk); #1;
        end
        chk("grant timeout", got, 1'b1);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic issue_m(input logic id, input logic [31:0] a,
                           input logic [31:0] b, input logic op);
        logic [36:0] r;
        r = dp_model(a, b, op);
        issue(id, a, b, op, r[31:0], r[36:32]);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++)
            @(posedge clk);
        @(posedge clk); #1;
        chk("scoreboard drained", sb.size(), 0);
    endtask

    typedef struct {
        logic        id;
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [31:0] d;
        logic [4:0]  e;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   base;
        logic got;

        tbl[0] = '{1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b00000};
        tbl[1] = '{1'b1, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 5'b11000};
        tbl[2] = '{1'b0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 5'b00000};
        tbl[3] = '{1'b1, 32'h40A00000, 32'h40400000, 1'b0, 32'h41000000, 5'b00000};
        tbl[4] = '{1'b1, 32'h3F800000, 32'h7F800000, 1'b0, 32'h7F800000, 5'b10001};
        tbl[5] = '{1'b0, 32'h3F800000, 32'h7FC00000, 1'b0, 32'h7FC00000, 5'b10100};
        tbl[6] = '{1'b0, 32'h41200000, 32'h40A00000, 1'b1, 32'h40A00000, 5'b00000};
        tbl[7] = '{1'b1, 32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, 5'b00000};

        rst = 1'b1; enable = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = 1'b0;
        req1_a = '0; req1_b = '0; req1_op = 1'b0;
        exp_d[0] = '0; exp_d[1] = '0; exp_e[0] = '0; exp_e[1] = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst req0_ready", req0_ready, 0);
        chk("rst req1_ready", req1_ready, 0);
        chk("rst fp_valid", fp_valid, 0);
        chk("rst fp_a", fp_a, 0);
        chk("rst fp_op", fp_op, 0);
        chk("rst res0_valid", res0_valid, 0);
        chk("rst res1_valid", res1_valid, 0);
        chk("rst res_data", res_data, 0);
        chk("rst res_exc", res_exc, 0);
        chk("rst busy", busy, 0);
`ifdef FPADDSUB_ARB_STATS_EN
        chk("rst issue_cnt0", issue_cnt0, 0);
        chk("rst issue_cnt1", issue_cnt1, 0);
`endif
        rst = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;

        // both valid: strict alternation starting with req0
        drive(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b0);
        drive(1'b1, 32'h40A00000, 32'h40400000, 1'b0, 32'h41000000, 5'b0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rr order", {req1_ready, req0_ready},
                (k % 2 == 1) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain();

        // table vectors, one at a time
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op,
                  tbl[i].d, tbl[i].e);
            wait_drain();
        end

        // three back-to-back, then enable drops: drain with no grants
        base = nres;
        drive(1'b0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 5'b0);
        got = 1'b0;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 20 && n < 3; k++) begin
                @(negedge clk);
                if (req0_ready) n++;
                @(posedge clk); #1;
            end
            chk("three issued", n, 3);
        end
        enable = 1'b0;
        @(negedge clk);
        chk("no grant enable low", req0_ready, 0);
        @(posedge clk); #1;
        enable = 1'b1;
        @(negedge clk);
        chk("no grant in drain", req0_ready, 0);
        @(posedge clk); #1;
        enable = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk); #1;
            chk("busy in drain", busy, 1);
            chk("ready in drain", req0_ready, 0);
            if (nres == base + 3) got = 1'b1;
        end
        chk("drain results", nres, base + 3);
        @(negedge clk); #1;
        chk("busy after drain", busy, 0);
        req0_valid = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;

        // reset two cycles after an issue discards the in-flight tag
        issue_m(1'b0, 32'h40400000, 32'h40000000, 1'b0);
        @(posedge clk); #1;
        base = nres;
        req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid-rst req1_ready", req1_ready, 0);
        chk("mid-rst fp_valid", fp_valid, 0);
        chk("mid-rst fp_a", fp_a, 0);
        chk("mid-rst busy", busy, 0);
        chk("mid-rst res0_valid", res0_valid, 0);
        chk("mid-rst res_data", res_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req1_valid = 1'b0;
        enable = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no res after rst", nres, base);
        chk("idle after rst", busy, 0);

`ifdef FPADDSUB_ARB_STATS_EN
        enable = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++)
            issue_m(1'b0, 32'h3F800000, 32'h3F800000, 1'b0);
        wait_drain();
        chk("issue_cnt0 saturated", issue_cnt0, 3);
        chk("issue_cnt1", issue_cnt1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/fpaddsub_arbiter.md
# fpaddsub_arbiter

Shares one fixed-latency single-precision FP add/sub pipeline between two requesters. Arbitration is round-robin; grants are issued at up to one operation per cycle. Each in-flight operation carries a tag so its result and exception flags return to the correct requester. The block sits between the requesting units and the FP add/sub datapath (prealign → align → execute → normalize → round) and sequences enable/drain of that pipeline.

## Interface
- LATENCY, 4, cycles from `fp_valid` sampled by the datapath to `fp_result`/`fp_exc` valid; legal range 1..16
- CNT_W, 16, width of the issue counters (only with `FPADDSUB_ARB_STATS_EN`)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  permits new grants
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  grant; a transfer occurs on valid&ready
- req0_a, req0_b / req1_a, req1_b  in  32  IEEE-754 single operands
- req0_op / req1_op  in  1  0 = add, 1 = subtract
- fp_valid  out  1  operation issued to the datapath
- fp_a, fp_b  out  32  operands to the datapath
- fp_op  out  1  operation to the datapath
- fp_result  in  32  datapath result
- fp_exc  in  5  datapath exception vector {any, ANaN, BNaN, AInf, BInf}
- res0_valid / res1_valid  out  1  result for requester 0/1; one-cycle pulse, no backpressure
- res_data  out  32  result, shared by both requesters
- res_exc  out  5  exception vector, shared by both requesters
- busy  out  1  state ≠ IDLE or any operation in flight
- issue_cnt0 / issue_cnt1  out  CNT_W  accepted-operation counts (macro only)

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset → IDLE.
- IDLE → RUN when `enable`=1.
- RUN → DRAIN when `enable`=0 and operations are in flight. RUN → IDLE when `enable`=0 and the tag pipe is empty.
- DRAIN → IDLE when the tag pipe is empty. Reasserting `enable` during DRAIN does not abort the drain. The path back to RUN is always via IDLE.
- Grants are issued only in RUN. `reqN_ready` is combinational from both valids and the priority pointer. Requesters must not make valid depend on ready.
- Round-robin rule: if only one requester is valid, it is granted. If both are valid, the requester not granted last is granted. The pointer updates only on a completed transfer. After reset the pointer favours req0.
- A request must hold its valid and operands stable until it is granted.
- Tag pipe: LATENCY+1 stages of {valid, id}. On a transfer, {1, N} is inserted; otherwise {0, x} is inserted.
- At the output stage, `resN_valid`, `res_data` and `res_exc` are registered from `fp_result`/`fp_exc`, and the id selects which `resN_valid` pulses. The two `resN_valid` outputs are never high together.
- Results leave in issue order; no reordering.

## Timing
- Reset values: every output 0 (ready, fp_*, res*, busy, counters); tag pipe cleared; pointer → req0.
- A transfer in cycle t produces registered `fp_valid`/`fp_a`/`fp_b`/`fp_op` in cycle t+1.
- `fp_result` is sampled in cycle t+1+LATENCY.
- `resN_valid`/`res_data`/`res_exc` appear in cycle t+2+LATENCY.
- Throughput: one operation per cycle sustained. Both requesters valid continuously → strict alternation.
- `rst` asserted mid-operation: all in-flight tags are discarded. Datapath results still emerging afterwards produce no `resN_valid`.
- `enable` dropping in the same cycle as a valid request: no grant in that cycle.
- `busy` stays high until the cycle after the last `resN_valid`.

## Configuration
- `FPADDSUB_ARB_STATS_EN` defined:
  - `issue_cnt0`/`issue_cnt1` ports exist.
  - Each increments on its requester's transfer.
  - Each saturates at 2^CNT_W−1.
  - Reset value 0.
- Not defined: the counter ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `fpaddsub_pkg`:
  - FP_W=32, EXC_W=5
  - state enum {IDLE, RUN, DRAIN}
  - tag struct {valid, id}
  - exception bit-index constants
- Sub-module `fpaddsub_tag_pipe`: parameterised depth shift register of tags, with async clear and an empty flag.

## Test plan
- LATENCY=4. req0 issues 0x3F800000 + 0x40000000, op=0, in cycle 0 → fp_valid in cycle 1; res0_valid=1 with res_data=0x40400000 and res_exc=0 in cycle 6; res1_valid stays 0.
- Both requesters valid for 6 cycles → grants in order 0,1,0,1,0,1; results return in the same order, one per cycle.
- req1 operand A=0x7FC00000 (NaN) → res1_valid with res_exc=5'b11000.
- Three operations issued, `enable` dropped in the next cycle → DRAIN, no grants; busy stays 1 through the third result pulse, then IDLE with busy=0.
- `rst` pulsed two cycles after an issue → all outputs 0 immediately; no resN_valid afterwards, despite the datapath returning a result.
- With `FPADDSUB_ARB_STATS_EN` and CNT_W=2, five req0 transfers → issue_cnt0=3 (saturated), issue_cnt1=0.
